max_reduce_ctrl: RTL

MAX_REDUCE_CTRL -- requirements
Module: max_reduce_ctrl

---
 rtl/max_pkg.sv | 13 +
 rtl/max_cmp_sel.sv | 15 +
 rtl/max_reduce_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/max_pkg.sv
// Shared definitions for the max-reduce controller: FSM encoding and default sizes.
package max_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_IDX_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/max_cmp_sel.sv
// Combinational unsigned compare-select: reports a > b (strict) and forwards the larger value.
module max_cmp_sel #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt,
   output logic [WIDTH-1:0] sel
);

   // Strict compare so that on a tie b (the incumbent) is kept.
   assign gt  = (a > b);
   assign sel = gt ? a : b;

endmodule

// File: rtl/max_reduce_ctrl.sv
// Frame max-reduction controller: tracks max value, its first position, beat count and overflow.
// Handshake: a beat/result transfers on a rising edge where valid and ready are both 1.
module max_reduce_ctrl
   import max_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [IDX_W-1:0] out_idx,
   output logic [IDX_W:0]   out_count,
   output logic             out_ovf,
   output logic [1:0]       o_dbg_state
);

   localparam logic [IDX_W:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};
   localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

   state_t             r_state;
   logic [WIDTH-1:0]   r_max;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W:0]     r_count;
   logic               r_ovf;
   logic               r_out_valid;

   logic               w_ready;
   logic               w_accept;
   logic               w_sat;
   logic               w_gt;
   logic [WIDTH-1:0]   w_sel;
   logic [IDX_W-1:0]   w_beat_idx;

   assign w_ready  = rst_n && (r_state != ST_HOLD);
   assign w_accept = in_valid && w_ready;
   assign w_sat    = (r_count == CNT_MAX);

   // Beats past capacity have no representable position; they report the last slot.
   assign w_beat_idx = w_sat ? {IDX_W{1'b1}} : r_count[IDX_W-1:0];

   max_cmp_sel #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .a   (in_data),
      .b   (r_max),
      .gt  (w_gt),
      .sel (w_sel)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_max       <= '0;
         r_idx       <= '0;
         r_count     <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_max   <= in_data;
                  r_idx   <= '0;
                  r_count <= CNT_ONE;
                  r_ovf   <= 1'b0;
                  if (in_last) begin
                     r_state     <= ST_HOLD;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state <= ST_ACC;
                  end
               end
            end
            ST_ACC: begin
               if (w_accept) begin
                  if (w_gt) begin
                     r_max <= w_sel;
                     r_idx <= w_beat_idx;
                  end
                  if (w_sat) begin
                     r_ovf <= 1'b1;
                  end else begin
                     r_count <= r_count + CNT_ONE;
                  end
                  if (in_last) begin
                     r_state     <= ST_HOLD;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               // Result registers are left untouched so they persist into IDLE.
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = w_ready;
   assign out_valid   = r_out_valid;
   assign out_max     = r_max;
   assign out_idx     = r_idx;
   assign out_count   = r_count;
   assign out_ovf     = r_ovf;
   assign o_dbg_state = r_state;

endmodule
